// File: rtl/zii_autoconfig.sv
// Zorro II AutoConfig responder: serves the nibble config ROM at $E8xxxx, latches BASE, then goes silent.
// Latency: 2 sync + max(WAIT_CYCLES,1) clocks to DSACK; releases 1 clock after synchronized AS rises.
module zii_autoconfig #(
    parameter logic [7:0]  PRODUCT      = 8'h01,
    parameter logic [15:0] MANUFACTURER = 16'h0A0D,
    parameter logic [31:0] SERIAL       = 32'h00000001,
    parameter logic [2:0]  SIZE_CODE    = 3'b000,
    parameter int unsigned WAIT_CYCLES  = 2
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        AS,
    input  logic        DS,
    input  logic        RW,
    input  logic [2:0]  FC,
    input  logic [23:0] A,
    input  logic [3:0]  DIN,
    output logic [3:0]  DOUT,
    output logic        DOE,
    output logic [1:0]  DSACK,
    output logic        CONFIGURED,
    output logic        SHUTUP,
    output logic [7:0]  BASE,
    output logic        RAM_MATCH
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        as_meta_q, as_meta_d, as_s_q, as_s_d;
    logic        ds_meta_q, ds_meta_d, ds_s_q, ds_s_d;
    logic [3:0]  dout_q, dout_d;
    logic        doe_q, doe_d;
    logic [1:0]  dsack_q, dsack_d;
    logic        cfg_q, cfg_d, shut_q, shut_d;
    logic [7:0]  base_q, base_d;
    logic        hit, go_ack, do_ack;
    logic [3:0]  rom_nib;
    logic        unused_addr;

    assign unused_addr = ^{A[15:7], A[0]};

    assign hit    = ~as_s_q & (A[23:16] == 8'hE8) & (FC != 3'b111) & ~cfg_q & ~shut_q;
    // Writes must not ack until the data strobe says DIN is valid.
    assign go_ack = ~as_s_q & (RW | ~ds_s_q);

    always_comb begin
        rom_nib = 4'hF;
        case (A[6:1])
            6'd0:  rom_nib = 4'hC;
            6'd1:  rom_nib = {1'b0, SIZE_CODE};
            6'd2:  rom_nib = ~PRODUCT[7:4];
            6'd3:  rom_nib = ~PRODUCT[3:0];
            6'd8:  rom_nib = ~MANUFACTURER[15:12];
            6'd9:  rom_nib = ~MANUFACTURER[11:8];
            6'd10: rom_nib = ~MANUFACTURER[7:4];
            6'd11: rom_nib = ~MANUFACTURER[3:0];
            6'd12: rom_nib = ~SERIAL[31:28];
            6'd13: rom_nib = ~SERIAL[27:24];
            6'd14: rom_nib = ~SERIAL[23:20];
            6'd15: rom_nib = ~SERIAL[19:16];
            6'd16: rom_nib = ~SERIAL[15:12];
            6'd17: rom_nib = ~SERIAL[11:8];
            6'd18: rom_nib = ~SERIAL[7:4];
            6'd19: rom_nib = ~SERIAL[3:0];
            default: rom_nib = 4'hF;
        endcase
    end

    always_comb begin
        as_meta_d = AS;
        as_s_d    = as_meta_q;
        ds_meta_d = DS;
        ds_s_d    = ds_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        doe_d     = doe_q;
        dsack_d   = dsack_q;
        cfg_d     = cfg_q;
        shut_d    = shut_q;
        base_d    = base_q;
        do_ack    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dsack_d = 2'b11;
                doe_d   = 1'b0;
                if (hit) begin
                    if (WAIT_LOAD <= 3'd1 && go_ack) begin
                        do_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (as_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q > 3'd1) cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd2 && go_ack) do_ack = 1'b1;
                end
            end
            ST_ACK, ST_HOLD: begin
                if (as_s_q) begin
                    state_d = ST_IDLE;
                    dsack_d = 2'b11;
                    doe_d   = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_ack) begin
            state_d = ST_ACK;
            dsack_d = 2'b10;
            cnt_d   = 3'd0;
            if (RW) begin
                dout_d = rom_nib;
                doe_d  = 1'b1;
            end else begin
                case (A[6:1])
                    6'd36: begin base_d[7:4] = DIN; cfg_d = 1'b1; end
                    6'd37: base_d[3:0] = DIN;
                    6'd38: shut_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLKCPU) begin
        if (!RESET) begin
            as_meta_q <= 1'b1;
            as_s_q    <= 1'b1;
            ds_meta_q <= 1'b1;
            ds_s_q    <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            dout_q    <= 4'h0;
            doe_q     <= 1'b0;
            dsack_q   <= 2'b11;
            cfg_q     <= 1'b0;
            shut_q    <= 1'b0;
            base_q    <= 8'h00;
        end else begin
            as_meta_q <= as_meta_d;
            as_s_q    <= as_s_d;
            ds_meta_q <= ds_meta_d;
            ds_s_q    <= ds_s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            dsack_q   <= dsack_d;
            cfg_q     <= cfg_d;
            shut_q    <= shut_d;
            base_q    <= base_d;
        end
    end

    assign DOUT       = dout_q;
    assign DOE        = doe_q;
    assign DSACK      = dsack_q;
    assign CONFIGURED = cfg_q;
    assign SHUTUP     = shut_q;
    assign BASE       = base_q;
    assign RAM_MATCH  = cfg_q & (A[23:21] == base_q[7:5]);

endmodule
